// File: rtl/bcam_match_resolver_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcam_pkg
// Brief  : Shared BCAM geometry and match-resolver state encoding.
// Rev    : 1.0
// ============================================================================
package bcam_pkg;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam int c_ST_W = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_EMIT = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_MISS = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bcam_match_resolver_if.sv
`default_nettype none
// ============================================================================
// Module : bcam_match_resolver_if
// Brief  : Search-in / hit-out handshake bundle of the BCAM match resolver.
// Rev    : 1.0
// ============================================================================
interface bcam_match_resolver_if #(
    parameter int DEPTH  = bcam_pkg::DEPTH,
    parameter int ADDR_W = bcam_pkg::ADDR_W
);
    logic              search_valid;
    logic              search_ready;
    logic [DEPTH-1:0]  match_vec;
    logic              hit_valid;
    logic              hit_ready;
    logic [ADDR_W-1:0] hit_addr;
    logic              hit_last;
    logic              miss;
    logic [ADDR_W:0]   match_count;

    modport master (
        output search_valid, match_vec, hit_ready,
        input  search_ready, hit_valid, hit_addr, hit_last, miss, match_count
    );

    modport slave (
        input  search_valid, match_vec, hit_ready,
        output search_ready, hit_valid, hit_addr, hit_last, miss, match_count
    );

endinterface
`default_nettype wire

// File: rtl/bcam_match_resolver_prio_enc.sv
`default_nettype none
// ============================================================================
// Module : bcam_prio_enc
// Brief  : Lowest-set-bit encoder with one-hot clear mask and single-bit flag.
// Rev    : 1.0
// ============================================================================
module bcam_prio_enc #(
    parameter int DEPTH  = bcam_pkg::DEPTH,
    parameter int ADDR_W = bcam_pkg::ADDR_W
) (
    input  wire logic [DEPTH-1:0]  i_vec,
    output logic      [ADDR_W-1:0] o_low_idx,
    output logic      [DEPTH-1:0]  o_low_mask,
    output logic                   o_single
);
    import bcam_pkg::*;

    localparam logic [DEPTH-1:0] c_ONE = DEPTH'(1);

    // Scan downward so the lowest set bit is the last (winning) assignment.
    always_comb begin
        o_low_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_low_idx = ADDR_W'(i);
            end
        end
    end

    assign o_low_mask = i_vec & (~i_vec + c_ONE);
    assign o_single   = (i_vec != '0) && ((i_vec & (i_vec - c_ONE)) == '0);

endmodule
`default_nettype wire

// File: rtl/bcam_match_resolver.sv
`default_nettype none
// ============================================================================
// Module : bcam_match_resolver
// Brief  : Captures a BCAM match vector and streams matching rows low-first.
// Rev    : 1.0
// ============================================================================
module bcam_match_resolver #(
    parameter int DEPTH  = bcam_pkg::DEPTH,
    parameter int ADDR_W = bcam_pkg::ADDR_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    bcam_match_resolver_if.slave  bus
);
    import bcam_pkg::*;

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_next;
    logic [DEPTH-1:0]  r_pending;
    logic [ADDR_W:0]   r_match_count;

    logic [ADDR_W-1:0] w_low_idx;
    logic [DEPTH-1:0]  w_low_mask;
    logic              w_single;

    logic              w_search_ready;
    logic              w_hit_valid;
    logic              w_hit_last;
    logic              w_miss;
    logic              w_accept;
    logic              w_beat;

    function automatic logic [ADDR_W:0] f_popcount(input logic [DEPTH-1:0] vec);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + (ADDR_W + 1)'(vec[i]);
        end
        return cnt;
    endfunction

    bcam_prio_enc #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prio_enc (
        .i_vec      (r_pending),
        .o_low_idx  (w_low_idx),
        .o_low_mask (w_low_mask),
        .o_single   (w_single)
    );

    assign w_accept = bus.search_valid && w_search_ready;
    assign w_beat   = w_hit_valid && bus.hit_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (bus.match_vec == '0) ? c_ST_MISS : c_ST_EMIT;
                end
            end
            c_ST_EMIT: begin
                if (w_beat && w_single) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_MISS: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_search_ready = 1'b0;
        w_hit_valid    = 1'b0;
        w_miss         = 1'b0;
        case (r_state)
            c_ST_IDLE: w_search_ready = 1'b1;
            c_ST_EMIT: w_hit_valid    = 1'b1;
            c_ST_MISS: w_miss         = 1'b1;
            default:   w_search_ready = 1'b0;
        endcase
    end

    // Pending only shrinks on an accepted beat, so stalls keep addr/last stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending     <= '0;
            r_match_count <= '0;
        end else if (w_accept) begin
            r_pending     <= bus.match_vec;
            r_match_count <= f_popcount(bus.match_vec);
        end else if (w_beat) begin
            r_pending     <= r_pending & ~w_low_mask;
        end
    end

    assign w_hit_last = w_hit_valid && w_single;

    assign bus.search_ready = w_search_ready;
    assign bus.hit_valid    = w_hit_valid;
    assign bus.hit_addr     = w_low_idx;
    assign bus.hit_last     = w_hit_last;
    assign bus.miss         = w_miss;
    assign bus.match_count  = r_match_count;

endmodule
`default_nettype wire

// File: tb/tb_bcam_match_resolver.sv
`default_nettype none
// ============================================================================
// Module : tb_bcam_match_resolver
// Brief  : Directed scoreboard bench for the BCAM match resolver.
// Rev    : 1.0
// ============================================================================
module tb_bcam_match_resolver;

    typedef struct packed {
        logic       is_miss;
        logic [3:0] addr;
        logic       last;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t q[$];

    bcam_match_resolver_if #(.DEPTH(16), .ADDR_W(4)) bus ();

    bcam_match_resolver #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hit(input int addr, input bit last);
        exp_t e;
        e.is_miss = 1'b0;
        e.addr    = 4'(addr);
        e.last    = last;
        q.push_back(e);
    endtask

    task automatic push_miss();
        exp_t e;
        e.is_miss = 1'b1;
        e.addr    = '0;
        e.last    = 1'b0;
        q.push_back(e);
    endtask

    // Output monitor: every miss pulse or accepted beat must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        chk("miss_hit_exclusive", 32'(bus.miss && bus.hit_valid), 0);
        if (bus.miss || (bus.hit_valid && bus.hit_ready)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_kind", 32'(bus.miss), 32'(e.is_miss));
                if (!e.is_miss) begin
                    chk("hit_addr", 32'(bus.hit_addr), 32'(e.addr));
                    chk("hit_last", 32'(bus.hit_last), 32'(e.last));
                end
            end
        end
    end

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        bus.search_valid = 1'b0;
        bus.match_vec    = '0;
        bus.hit_ready    = 1'b0;
        #2;
        chk("rst_search_ready", 32'(bus.search_ready), 1);
        chk("rst_hit_valid",    32'(bus.hit_valid), 0);
        chk("rst_miss",         32'(bus.miss), 0);
        chk("rst_match_count",  32'(bus.match_count), 0);
        chk("rst_hit_addr",     32'(bus.hit_addr), 0);
        chk("rst_hit_last",     32'(bus.hit_last), 0);
        step();
        step();
        rst = 1'b1;
        step();

        // 1: all-zero vector -> single miss pulse
        bus.match_vec    = 16'h0000;
        bus.search_valid = 1'b1;
        push_miss();
        step();
        bus.search_valid = 1'b0;
        chk("t1_miss",        32'(bus.miss), 1);
        chk("t1_hit_valid",   32'(bus.hit_valid), 0);
        chk("t1_match_count", 32'(bus.match_count), 0);
        chk("t1_ready_busy",  32'(bus.search_ready), 0);
        step();
        chk("t1_miss_drop",   32'(bus.miss), 0);
        chk("t1_ready_back",  32'(bus.search_ready), 1);

        // 2: 16'h8421 streamed at full rate
        bus.hit_ready    = 1'b1;
        bus.match_vec    = 16'h8421;
        bus.search_valid = 1'b1;
        push_hit(0, 0); push_hit(5, 0); push_hit(10, 0); push_hit(15, 1);
        step();
        bus.search_valid = 1'b0;
        chk("t2_match_count", 32'(bus.match_count), 4);
        chk("t2_hit_valid",   32'(bus.hit_valid), 1);
        chk("t2_ready_busy",  32'(bus.search_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_ready_busy", 32'(bus.search_ready), 0);
        end
        step();
        chk("t2_ready_back",  32'(bus.search_ready), 1);
        chk("t2_hit_valid_off", 32'(bus.hit_valid), 0);

        // 3: backpressure holds the first beat
        bus.hit_ready    = 1'b0;
        bus.match_vec    = 16'h0006;
        bus.search_valid = 1'b1;
        push_hit(1, 0); push_hit(2, 1);
        step();
        bus.search_valid = 1'b0;
        chk("t3_match_count", 32'(bus.match_count), 2);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", 32'(bus.hit_valid), 1);
            chk("t3_hold_addr",  32'(bus.hit_addr), 1);
            chk("t3_hold_last",  32'(bus.hit_last), 0);
            if (i < 2) step();
        end
        bus.hit_ready = 1'b1;
        step();
        chk("t3_second_addr", 32'(bus.hit_addr), 2);
        chk("t3_second_last", 32'(bus.hit_last), 1);
        step();
        chk("t3_ready_back",  32'(bus.search_ready), 1);

        // 4: full vector, request held, new data presented during EMIT
        bus.match_vec    = 16'hFFFF;
        bus.search_valid = 1'b1;
        for (int i = 0; i < 16; i++) push_hit(i, i == 15);
        push_hit(0, 1);
        step();
        bus.match_vec = 16'h0001;
        chk("t4_match_count", 32'(bus.match_count), 16);
        for (int i = 0; i < 16; i++) step();
        chk("t4_idle_ready",  32'(bus.search_ready), 1);
        chk("t4_idle_hv",     32'(bus.hit_valid), 0);
        chk("t4_count_held",  32'(bus.match_count), 16);
        step();
        bus.search_valid = 1'b0;
        chk("t4_second_count", 32'(bus.match_count), 1);
        chk("t4_second_addr",  32'(bus.hit_addr), 0);
        chk("t4_second_last",  32'(bus.hit_last), 1);
        step();
        chk("t4_ready_back",  32'(bus.search_ready), 1);

        // 5: asynchronous reset in the middle of a burst
        bus.match_vec    = 16'hFFFF;
        bus.search_valid = 1'b1;
        push_hit(0, 0); push_hit(1, 0);
        step();
        bus.search_valid = 1'b0;
        step();
        step();
        chk("t5_pre_rst_addr", 32'(bus.hit_addr), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_hit_valid",   32'(bus.hit_valid), 0);
        chk("t5_rst_hit_addr",    32'(bus.hit_addr), 0);
        chk("t5_rst_match_count", 32'(bus.match_count), 0);
        chk("t5_rst_ready",       32'(bus.search_ready), 1);
        step();
        rst = 1'b1;
        bus.match_vec    = 16'h0010;
        bus.search_valid = 1'b1;
        push_hit(4, 1);
        step();
        bus.search_valid = 1'b0;
        chk("t5_new_count", 32'(bus.match_count), 1);
        chk("t5_new_addr",  32'(bus.hit_addr), 4);
        chk("t5_new_last",  32'(bus.hit_last), 1);
        step();
        chk("t5_ready_back", 32'(bus.search_ready), 1);

        // 6: back-to-back hit then miss
        bus.match_vec    = 16'h0001;
        bus.search_valid = 1'b1;
        push_hit(0, 1);
        step();
        bus.match_vec = 16'h0000;
        push_miss();
        chk("t6_hit_valid",  32'(bus.hit_valid), 1);
        chk("t6_ready_busy", 32'(bus.search_ready), 0);
        step();
        chk("t6_ready_idle", 32'(bus.search_ready), 1);
        step();
        bus.search_valid = 1'b0;
        chk("t6_miss",       32'(bus.miss), 1);
        chk("t6_count",      32'(bus.match_count), 0);
        step();
        chk("t6_miss_drop",  32'(bus.miss), 0);
        chk("t6_ready_back", 32'(bus.search_ready), 1);

        repeat (3) step();
        chk("queue_drained", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
